ex_operand_stage: RTL and testbench
===================================

EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

Interface
REQ-001 The block SHALL have parameter FWD_EN, default 1, meaning: 1 enables MEM/WB operand forwarding, 0 always uses register-file data.
REQ-002 The block SHALL have port i_clk  input  1  system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port i_id_valid  input  1  decode stage presents an instruction.
REQ-005 The block SHALL have port o_id_ready  output  1  block accepts the decode instruction this cycle.
REQ-006 The block SHALL have ports i_id_rs1_data, i_id_rs2_data, i_id_imm, i_id_pc  input  32 each  register-file operands, sign-extended immediate, instruction PC.
REQ-007 The block SHALL have ports i_id_rs1_addr, i_id_rs2_addr, i_id_rd_addr  input  5 each  source and destination register indices.
REQ-008 The block SHALL have ports i_id_aluctrl  input  4  ALU op code (ADD 0000, SUB 1000, SLT 0010, SLTU 0011, AND 0111, OR 0110, XOR 0100, SLL 0001, SRL 0101, SRA 1101); i_id_alusrc_a  input  2  A select (00 rs1, 01 pc, 10 zero, 11 reserved, treated as zero); i_id_alusrc_b  input  1  B select (0 rs2, 1 imm); i_id_regwrite  input  1.
REQ-009 The block SHALL have port i_flush  input  1  discards the held instruction and any instruction offered this cycle.
REQ-010 The block SHALL have ports i_mem_regwrite  input  1, i_mem_rd_addr  input  5, i_mem_result  input  32, and i_wb_regwrite  input  1, i_wb_rd_addr  input  5, i_wb_result  input  32: forwarding sources.
REQ-011 The block SHALL have ports o_ex_valid  output  1 and i_ex_ready  input  1: handshake to the downstream stage.
REQ-012 The block SHALL have ports o_alu_a, o_alu_b  output  32  ALU operands; o_aluctrl_ctrl  output  4  ALU op; o_ex_store_data  output  32  forwarded rs2; o_ex_rd_addr  output  5; o_ex_regwrite  output  1.

Function
REQ-013 The block SHALL hold one instruction in a single register slot with valid flag V; o_ex_valid SHALL equal V.
REQ-014 o_id_ready SHALL be (!V || i_ex_ready) && !i_flush.
REQ-015 On a clock edge with i_flush=1, V SHALL become 0 regardless of all other inputs.
REQ-016 Otherwise, when i_id_valid && o_id_ready, the slot SHALL capture all decode fields and set V=1 (a simultaneous downstream accept and new capture gives zero bubbles).
REQ-017 Otherwise, when V && i_ex_ready, V SHALL become 0.
REQ-018 Otherwise, when V && !i_ex_ready (stall), the held rs1/rs2 data SHALL be overwritten with the current forwarded values of REQ-019, so a producer retiring during the stall is not lost; all other fields SHALL hold.
REQ-019 Forwarded rsN (N=1,2), evaluated combinationally from the held rsN address: if FWD_EN && i_mem_regwrite && i_mem_rd_addr==rsN && rsN!=0 then i_mem_result; else if FWD_EN && i_wb_regwrite && i_wb_rd_addr==rsN && rsN!=0 then i_wb_result; else held rsN data. MEM SHALL have priority over WB.
REQ-020 o_alu_a SHALL be forwarded rs1, held pc, or 32'h0 per the held alusrc_a; o_alu_b SHALL be forwarded rs2 or held imm per alusrc_b; o_ex_store_data SHALL always be forwarded rs2.
REQ-021 Register x0 SHALL never be forwarded; rs=0 yields the held data unchanged.
REQ-022 Outputs other than o_ex_valid and o_id_ready SHALL be don't-care when V=0, but SHALL be deterministic (no X) after reset.
REQ-023 o_ex_regwrite SHALL be the held regwrite ANDed with V.
REQ-024 Latency from decode acceptance to o_ex_valid SHALL be exactly one cycle.

Reset
REQ-025 While i_rst_n=0, V and every held field SHALL be 0 asynchronously: o_ex_valid=0, o_ex_regwrite=0, o_aluctrl_ctrl=4'b0000, held operands 0.
REQ-026 During reset o_id_ready SHALL follow REQ-014 with V=0; instructions SHALL NOT be captured until the first edge after deassertion.
REQ-027 Reset asserted mid-stall SHALL drop the held instruction; no partial state SHALL survive.

Verification
REQ-028 Offer rs1_data=5, imm=7, alusrc_b=1, aluctrl=0000, i_ex_ready=1 -> next cycle o_ex_valid=1, o_alu_a=5, o_alu_b=7, o_aluctrl_ctrl=0000.
REQ-029 Hold rs1=3; mem writes x3=0xAA, wb writes x3=0xBB -> o_alu_a=0xAA; with mem regwrite=0 -> 0xBB; with rs1=0 and both writing x0 -> held data.
REQ-030 V=1, i_ex_ready=0 for 3 cycles, wb forwards x2=0x55 in cycle 1 only -> o_alu_b stays 0x55 in cycles 2-3 (refresh), o_id_ready=0 throughout.
REQ-031 Back-to-back accept with i_ex_ready=1 for 4 instructions -> o_ex_valid=1 for 4 consecutive cycles, no bubbles, order preserved.
REQ-032 i_flush=1 with i_id_valid=1 and V=1 -> next cycle o_ex_valid=0, nothing captured; o_id_ready=0 during the flush cycle.
REQ-033 Assert i_rst_n=0 mid-stall between edges -> o_ex_valid=0 immediately, o_ex_regwrite=0; FWD_EN=0 build -> forwarded sources ignored.

Source files
------------

// File: rtl/ex_operand_stage_if.sv
// Decode-to-execute operand stage bus: decode offer, forwarding sources
// and the downstream handshake/operands.
interface ex_operand_stage_if;
    logic        i_id_valid;
    logic        o_id_ready;
    logic [31:0] i_id_rs1_data;
    logic [31:0] i_id_rs2_data;
    logic [31:0] i_id_imm;
    logic [31:0] i_id_pc;
    logic [4:0]  i_id_rs1_addr;
    logic [4:0]  i_id_rs2_addr;
    logic [4:0]  i_id_rd_addr;
    logic [3:0]  i_id_aluctrl;
    logic [1:0]  i_id_alusrc_a;
    logic        i_id_alusrc_b;
    logic        i_id_regwrite;
    logic        i_flush;
    logic        i_mem_regwrite;
    logic [4:0]  i_mem_rd_addr;
    logic [31:0] i_mem_result;
    logic        i_wb_regwrite;
    logic [4:0]  i_wb_rd_addr;
    logic [31:0] i_wb_result;
    logic        o_ex_valid;
    logic        i_ex_ready;
    logic [31:0] o_alu_a;
    logic [31:0] o_alu_b;
    logic [3:0]  o_aluctrl_ctrl;
    logic [31:0] o_ex_store_data;
    logic [4:0]  o_ex_rd_addr;
    logic        o_ex_regwrite;

    modport slave (
        input  i_id_valid, i_id_rs1_data, i_id_rs2_data, i_id_imm, i_id_pc,
               i_id_rs1_addr, i_id_rs2_addr, i_id_rd_addr, i_id_aluctrl,
               i_id_alusrc_a, i_id_alusrc_b, i_id_regwrite, i_flush,
               i_mem_regwrite, i_mem_rd_addr, i_mem_result,
               i_wb_regwrite, i_wb_rd_addr, i_wb_result, i_ex_ready,
        output o_id_ready, o_ex_valid, o_alu_a, o_alu_b, o_aluctrl_ctrl,
               o_ex_store_data, o_ex_rd_addr, o_ex_regwrite
    );

    modport master (
        output i_id_valid, i_id_rs1_data, i_id_rs2_data, i_id_imm, i_id_pc,
               i_id_rs1_addr, i_id_rs2_addr, i_id_rd_addr, i_id_aluctrl,
               i_id_alusrc_a, i_id_alusrc_b, i_id_regwrite, i_flush,
               i_mem_regwrite, i_mem_rd_addr, i_mem_result,
               i_wb_regwrite, i_wb_rd_addr, i_wb_result, i_ex_ready,
        input  o_id_ready, o_ex_valid, o_alu_a, o_alu_b, o_aluctrl_ctrl,
               o_ex_store_data, o_ex_rd_addr, o_ex_regwrite
    );
endinterface

// File: rtl/ex_operand_stage.sv
// Single-slot execute operand stage: holds one decoded instruction, forwards
// MEM/WB results into its sources and selects the ALU operands.
module ex_operand_stage #(
    parameter int unsigned FWD_EN = 1
) (
    input logic              i_clk,
    input logic              i_rst_n,
    ex_operand_stage_if.slave bus
);
    localparam bit FWD_ON = (FWD_EN != 0);

    typedef struct packed {
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic [3:0]  aluctrl;
        logic [1:0]  alusrc_a;
        logic        alusrc_b;
        logic        regwrite;
    } slot_t;

    slot_t       slot;
    logic        v;
    logic        id_ready;
    logic        id_fire;
    logic [31:0] rs1_fwd;
    logic [31:0] rs2_fwd;

    assign id_ready = (!v || bus.i_ex_ready) && !bus.i_flush;
    assign id_fire  = bus.i_id_valid && id_ready;

    // MEM beats WB; x0 is never forwarded.
    always_comb begin
        rs1_fwd = slot.rs1_data;
        rs2_fwd = slot.rs2_data;
        if (FWD_ON && slot.rs1_addr != 5'd0) begin
            if (bus.i_mem_regwrite && bus.i_mem_rd_addr == slot.rs1_addr)
                rs1_fwd = bus.i_mem_result;
            else if (bus.i_wb_regwrite && bus.i_wb_rd_addr == slot.rs1_addr)
                rs1_fwd = bus.i_wb_result;
        end
        if (FWD_ON && slot.rs2_addr != 5'd0) begin
            if (bus.i_mem_regwrite && bus.i_mem_rd_addr == slot.rs2_addr)
                rs2_fwd = bus.i_mem_result;
            else if (bus.i_wb_regwrite && bus.i_wb_rd_addr == slot.rs2_addr)
                rs2_fwd = bus.i_wb_result;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v    <= 1'b0;
            slot <= '0;
        end else if (bus.i_flush) begin
            v <= 1'b0;
        end else if (id_fire) begin
            v             <= 1'b1;
            slot.rs1_data <= bus.i_id_rs1_data;
            slot.rs2_data <= bus.i_id_rs2_data;
            slot.imm      <= bus.i_id_imm;
            slot.pc       <= bus.i_id_pc;
            slot.rs1_addr <= bus.i_id_rs1_addr;
            slot.rs2_addr <= bus.i_id_rs2_addr;
            slot.rd_addr  <= bus.i_id_rd_addr;
            slot.aluctrl  <= bus.i_id_aluctrl;
            slot.alusrc_a <= bus.i_id_alusrc_a;
            slot.alusrc_b <= bus.i_id_alusrc_b;
            slot.regwrite <= bus.i_id_regwrite;
        end else if (v && bus.i_ex_ready) begin
            v <= 1'b0;
        end else if (v) begin
            // Stalled: latch forwarded values so a producer retiring now is kept.
            slot.rs1_data <= rs1_fwd;
            slot.rs2_data <= rs2_fwd;
        end
    end

    always_comb begin
        case (slot.alusrc_a)
            2'b00:   bus.o_alu_a = rs1_fwd;
            2'b01:   bus.o_alu_a = slot.pc;
            default: bus.o_alu_a = 32'h0;
        endcase
    end

    assign bus.o_id_ready      = id_ready;
    assign bus.o_ex_valid      = v;
    assign bus.o_alu_b         = slot.alusrc_b ? slot.imm : rs2_fwd;
    assign bus.o_aluctrl_ctrl  = slot.aluctrl;
    assign bus.o_ex_store_data = rs2_fwd;
    assign bus.o_ex_rd_addr    = slot.rd_addr;
    assign bus.o_ex_regwrite   = slot.regwrite && v;
endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: forwarding and non-forwarding builds driven in
// lockstep, checked against a slot-level reference model.
module tb_ex_operand_stage;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        i_id_valid, i_id_alusrc_b, i_id_regwrite, i_flush, i_ex_ready;
    logic [31:0] i_id_rs1_data, i_id_rs2_data, i_id_imm, i_id_pc;
    logic [4:0]  i_id_rs1_addr, i_id_rs2_addr, i_id_rd_addr;
    logic [3:0]  i_id_aluctrl;
    logic [1:0]  i_id_alusrc_a;
    logic        i_mem_regwrite, i_wb_regwrite;
    logic [4:0]  i_mem_rd_addr, i_wb_rd_addr;
    logic [31:0] i_mem_result, i_wb_result;

    ex_operand_stage_if bus0 ();
    ex_operand_stage_if bus1 ();

    assign bus0.i_id_valid = i_id_valid;         assign bus1.i_id_valid = i_id_valid;
    assign bus0.i_id_rs1_data = i_id_rs1_data;   assign bus1.i_id_rs1_data = i_id_rs1_data;
    assign bus0.i_id_rs2_data = i_id_rs2_data;   assign bus1.i_id_rs2_data = i_id_rs2_data;
    assign bus0.i_id_imm = i_id_imm;             assign bus1.i_id_imm = i_id_imm;
    assign bus0.i_id_pc = i_id_pc;               assign bus1.i_id_pc = i_id_pc;
    assign bus0.i_id_rs1_addr = i_id_rs1_addr;   assign bus1.i_id_rs1_addr = i_id_rs1_addr;
    assign bus0.i_id_rs2_addr = i_id_rs2_addr;   assign bus1.i_id_rs2_addr = i_id_rs2_addr;
    assign bus0.i_id_rd_addr = i_id_rd_addr;     assign bus1.i_id_rd_addr = i_id_rd_addr;
    assign bus0.i_id_aluctrl = i_id_aluctrl;     assign bus1.i_id_aluctrl = i_id_aluctrl;
    assign bus0.i_id_alusrc_a = i_id_alusrc_a;   assign bus1.i_id_alusrc_a = i_id_alusrc_a;
    assign bus0.i_id_alusrc_b = i_id_alusrc_b;   assign bus1.i_id_alusrc_b = i_id_alusrc_b;
    assign bus0.i_id_regwrite = i_id_regwrite;   assign bus1.i_id_regwrite = i_id_regwrite;
    assign bus0.i_flush = i_flush;               assign bus1.i_flush = i_flush;
    assign bus0.i_mem_regwrite = i_mem_regwrite; assign bus1.i_mem_regwrite = i_mem_regwrite;
    assign bus0.i_mem_rd_addr = i_mem_rd_addr;   assign bus1.i_mem_rd_addr = i_mem_rd_addr;
    assign bus0.i_mem_result = i_mem_result;     assign bus1.i_mem_result = i_mem_result;
    assign bus0.i_wb_regwrite = i_wb_regwrite;   assign bus1.i_wb_regwrite = i_wb_regwrite;
    assign bus0.i_wb_rd_addr = i_wb_rd_addr;     assign bus1.i_wb_rd_addr = i_wb_rd_addr;
    assign bus0.i_wb_result = i_wb_result;       assign bus1.i_wb_result = i_wb_result;
    assign bus0.i_ex_ready = i_ex_ready;         assign bus1.i_ex_ready = i_ex_ready;

    ex_operand_stage #(.FWD_EN(0)) u_dut0 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus0));
    ex_operand_stage #(.FWD_EN(1)) u_dut1 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus1));

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: one instruction slot per build (index 0 = no forwarding).
    typedef struct {
        logic        v;
        logic [31:0] rs1d, rs2d, imm, pc;
        logic [4:0]  rs1a, rs2a, rd;
        logic [3:0]  ctrl;
        logic [1:0]  srca;
        logic        srcb, rw;
    } mdl_t;
    mdl_t m[2];

    function automatic logic [31:0] mfwd(input bit en, input logic [4:0] a, input logic [31:0] held);
        if (!en || a == 0) return held;
        if (i_mem_regwrite && i_mem_rd_addr == a) return i_mem_result;
        if (i_wb_regwrite && i_wb_rd_addr == a) return i_wb_result;
        return held;
    endfunction

    task automatic mreset();
        for (int k = 0; k < 2; k++) begin
            m[k].v = 0; m[k].rs1d = 0; m[k].rs2d = 0; m[k].imm = 0; m[k].pc = 0;
            m[k].rs1a = 0; m[k].rs2a = 0; m[k].rd = 0; m[k].ctrl = 0;
            m[k].srca = 0; m[k].srcb = 0; m[k].rw = 0;
        end
    endtask

    task automatic chk_dut(input int k, input logic v, input logic rdy, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] c, input logic [31:0] st,
                           input logic [4:0] rd, input logic rw);
        logic [31:0] f1, f2, ea;
        f1 = mfwd(k == 1, m[k].rs1a, m[k].rs1d);
        f2 = mfwd(k == 1, m[k].rs2a, m[k].rs2d);
        ea = (m[k].srca == 2'd0) ? f1 : (m[k].srca == 2'd1) ? m[k].pc : 32'h0;
        chk($sformatf("d%0d_valid", k), 32'(v), 32'(m[k].v));
        chk($sformatf("d%0d_ready", k), 32'(rdy), 32'((!m[k].v || i_ex_ready) && !i_flush));
        chk($sformatf("d%0d_regwrite", k), 32'(rw), 32'(m[k].v && m[k].rw));
        if (m[k].v) begin
            chk($sformatf("d%0d_alu_a", k), a, ea);
            chk($sformatf("d%0d_alu_b", k), b, m[k].srcb ? m[k].imm : f2);
            chk($sformatf("d%0d_ctrl", k), 32'(c), 32'(m[k].ctrl));
            chk($sformatf("d%0d_store", k), st, f2);
            chk($sformatf("d%0d_rd", k), 32'(rd), 32'(m[k].rd));
        end
    endtask

    // Called with inputs set just after a falling edge; returns at the next falling edge.
    task automatic step();
        mdl_t nx[2];
        bit   rdy;
        #1;
        chk_dut(0, bus0.o_ex_valid, bus0.o_id_ready, bus0.o_alu_a, bus0.o_alu_b,
                bus0.o_aluctrl_ctrl, bus0.o_ex_store_data, bus0.o_ex_rd_addr, bus0.o_ex_regwrite);
        chk_dut(1, bus1.o_ex_valid, bus1.o_id_ready, bus1.o_alu_a, bus1.o_alu_b,
                bus1.o_aluctrl_ctrl, bus1.o_ex_store_data, bus1.o_ex_rd_addr, bus1.o_ex_regwrite);
        for (int k = 0; k < 2; k++) begin
            nx[k] = m[k];
            rdy = (!m[k].v || i_ex_ready) && !i_flush;
            if (i_flush) nx[k].v = 0;
            else if (i_id_valid && rdy) begin
                nx[k].v = 1; nx[k].rs1d = i_id_rs1_data; nx[k].rs2d = i_id_rs2_data;
                nx[k].imm = i_id_imm; nx[k].pc = i_id_pc; nx[k].rs1a = i_id_rs1_addr;
                nx[k].rs2a = i_id_rs2_addr; nx[k].rd = i_id_rd_addr; nx[k].ctrl = i_id_aluctrl;
                nx[k].srca = i_id_alusrc_a; nx[k].srcb = i_id_alusrc_b; nx[k].rw = i_id_regwrite;
            end else if (m[k].v && i_ex_ready) nx[k].v = 0;
            else if (m[k].v) begin
                nx[k].rs1d = mfwd(k == 1, m[k].rs1a, m[k].rs1d);
                nx[k].rs2d = mfwd(k == 1, m[k].rs2a, m[k].rs2d);
            end
        end
        @(posedge clk);
        m[0] = nx[0];
        m[1] = nx[1];
        @(negedge clk);
    endtask

    task automatic idle_in();
        i_id_valid = 0; i_id_rs1_data = 0; i_id_rs2_data = 0; i_id_imm = 0; i_id_pc = 0;
        i_id_rs1_addr = 0; i_id_rs2_addr = 0; i_id_rd_addr = 0; i_id_aluctrl = 0;
        i_id_alusrc_a = 0; i_id_alusrc_b = 0; i_id_regwrite = 0; i_flush = 0;
        i_mem_regwrite = 0; i_mem_rd_addr = 0; i_mem_result = 0;
        i_wb_regwrite = 0; i_wb_rd_addr = 0; i_wb_result = 0; i_ex_ready = 1;
    endtask

    logic [3:0] ops[10] = '{4'b0000, 4'b1000, 4'b0010, 4'b0011, 4'b0111,
                            4'b0110, 4'b0100, 4'b0001, 4'b0101, 4'b1101};

    task automatic rand_in();
        i_id_valid = ($urandom_range(9) < 7); i_id_rs1_data = $urandom; i_id_rs2_data = $urandom;
        i_id_imm = $urandom; i_id_pc = $urandom; i_id_rs1_addr = 5'($urandom_range(3));
        i_id_rs2_addr = 5'($urandom_range(3)); i_id_rd_addr = 5'($urandom_range(31));
        i_id_aluctrl = ops[$urandom_range(9)]; i_id_alusrc_a = 2'($urandom_range(3));
        i_id_alusrc_b = 1'($urandom_range(1)); i_id_regwrite = 1'($urandom_range(1));
        i_flush = ($urandom_range(9) == 0); i_ex_ready = ($urandom_range(9) < 6);
        i_mem_regwrite = 1'($urandom_range(1)); i_mem_rd_addr = 5'($urandom_range(3));
        i_mem_result = $urandom; i_wb_regwrite = 1'($urandom_range(1));
        i_wb_rd_addr = 5'($urandom_range(3)); i_wb_result = $urandom;
    endtask

    initial begin
        rst_n = 0;
        idle_in();
        i_ex_ready = 0;
        mreset();
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_valid", 32'(bus1.o_ex_valid), 0);
        chk("rst_regwrite", 32'(bus1.o_ex_regwrite), 0);
        chk("rst_ctrl", 32'(bus1.o_aluctrl_ctrl), 0);
        chk("rst_alu_a", bus1.o_alu_a, 0);
        chk("rst_alu_b", bus1.o_alu_b, 0);
        chk("rst_ready", 32'(bus1.o_id_ready), 1);
        // Offered during reset: must not be captured.
        i_id_valid = 1;
        @(negedge clk);
        chk("rst_nocap", 32'(bus1.o_ex_valid), 0);
        rst_n = 1;
        idle_in();

        // Basic capture, one-cycle latency.
        i_id_valid = 1; i_id_rs1_data = 5; i_id_imm = 7; i_id_alusrc_b = 1;
        step();
        idle_in();
        #1;
        chk("bas_valid", 32'(bus1.o_ex_valid), 1);
        chk("bas_a", bus1.o_alu_a, 5);
        chk("bas_b", bus1.o_alu_b, 7);
        chk("bas_ctrl", 32'(bus1.o_aluctrl_ctrl), 0);
        step();

        // Forwarding priority and x0.
        i_id_valid = 1; i_id_rs1_addr = 3; i_id_rs1_data = 32'h33;
        step();
        idle_in(); i_ex_ready = 0;
        i_mem_regwrite = 1; i_mem_rd_addr = 3; i_mem_result = 32'hAA;
        i_wb_regwrite = 1; i_wb_rd_addr = 3; i_wb_result = 32'hBB;
        #1;
        chk("fwd_mem", bus1.o_alu_a, 32'hAA);
        chk("nofwd_held", bus0.o_alu_a, 32'h33);
        step();
        i_mem_regwrite = 0;
        #1;
        chk("fwd_wb", bus1.o_alu_a, 32'hBB);
        step();
        i_ex_ready = 1; i_id_valid = 1; i_id_rs1_addr = 0; i_id_rs1_data = 32'h44;
        i_mem_rd_addr = 0; i_wb_rd_addr = 0; i_mem_regwrite = 1;
        step();
        i_id_valid = 0;
        #1;
        chk("fwd_x0", bus1.o_alu_a, 32'h44);
        step();

        // Stall refresh: WB retires x2 only in the first stall cycle.
        idle_in();
        i_id_valid = 1; i_id_rs2_addr = 2; i_id_rs2_data = 32'h11; i_id_rd_addr = 9; i_id_regwrite = 1;
        step();
        i_ex_ready = 0; i_id_rs2_data = 32'h99;
        i_wb_regwrite = 1; i_wb_rd_addr = 2; i_wb_result = 32'h55;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) i_wb_regwrite = 0;
            #1;
            chk("stl_b", bus1.o_alu_b, 32'h55);
            chk("stl_ready", 32'(bus1.o_id_ready), 0);
            step();
        end

        // Reset between edges while stalled.
        #2 rst_n = 0;
        #1;
        chk("rst_mid_valid", 32'(bus1.o_ex_valid), 0);
        chk("rst_mid_rw", 32'(bus1.o_ex_regwrite), 0);
        mreset();
        @(negedge clk);
        rst_n = 1;
        idle_in();

        // Four back-to-back instructions, no bubbles.
        for (int n = 0; n < 5; n++) begin
            i_id_valid = (n < 4); i_id_rd_addr = 5'(n + 1); i_id_regwrite = 1;
            if (n > 0) begin
                #1;
                chk("b2b_valid", 32'(bus1.o_ex_valid), 1);
                chk("b2b_rd", 32'(bus1.o_ex_rd_addr), 32'(n));
            end
            step();
        end

        // Flush with a held and an offered instruction.
        idle_in(); i_id_valid = 1; i_id_rd_addr = 7;
        step();
        i_flush = 1; i_id_rd_addr = 8; i_ex_ready = 0;
        #1;
        chk("fl_ready", 32'(bus1.o_id_ready), 0);
        step();
        idle_in();
        #1;
        chk("fl_valid", 32'(bus1.o_ex_valid), 0);
        step();

        for (int n = 0; n < 400; n++) begin
            rand_in();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
